// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: FSM states, 640x480 visible-area constants and the signed 11-bit position type for ball motion
package ball_motion_pkg;
  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y} state_t;
  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  typedef logic signed [10:0] pos_t;
endpackage

// File: rtl/ball_motion_controller_vsync_edge_detect.sv
// vsync_edge_detect: one-register level-to-pulse frame tick; ports i_clk, i_rst, i_vsync -> o_tick (high while i_vsync==POL and previous sample was not)
module vsync_edge_detect #(
  parameter bit POL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_tick
);
  logic prev;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) prev <= ~POL;
    else prev <= i_vsync;
  assign o_tick = (i_vsync == POL) && (prev != POL);
endmodule

// File: rtl/ball_motion_controller.sv
// ball_motion_controller: per-frame ball X/Y stepper with edge bounce plus registered ball-on flag; in i_clk,i_rst,i_vsync,i_enable,i_hpos,i_vpos,i_visible; out o_ball_x,o_ball_y,o_ball_on,o_busy,o_bounce_x,o_bounce_y, and o_bounce_count when BALL_MOTION_BOUNCE_COUNT_EN is defined
module ball_motion_controller
  import ball_motion_pkg::*;
#(
  parameter int H_VISIBLE = H_VIS,
  parameter int V_VISIBLE = V_VIS,
  parameter int BALL_SIZE = 8,
  parameter int X_INIT    = 128,
  parameter int Y_INIT    = 128,
  parameter int X_SPEED   = 2,
  parameter int Y_SPEED   = 2,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vsync,
  input  logic       i_enable,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_visible,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic       o_ball_on,
  output logic       o_busy,
  output logic       o_bounce_x,
  output logic       o_bounce_y
`ifdef BALL_MOTION_BOUNCE_COUNT_EN
  ,
  output logic [15:0] o_bounce_count
`endif
);
  localparam pos_t X_MAX = pos_t'(H_VISIBLE - BALL_SIZE);
  localparam pos_t Y_MAX = pos_t'(V_VISIBLE - BALL_SIZE);
  localparam pos_t X_STEP = pos_t'(X_SPEED);
  localparam pos_t Y_STEP = pos_t'(Y_SPEED);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  state_t state, state_n;
  logic tick, dir_x, dir_y, hi_x, lo_x, hi_y, lo_y, on;
  pos_t cand_x, cand_y;
  vsync_edge_detect #(.POL(VSYNC_POL)) u_vsync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vsync(i_vsync),
    .o_tick (tick)
  );
  always_comb begin
    state_n = state == IDLE ? ((tick && i_enable) ? STEP_X : IDLE) : state == STEP_X ? STEP_Y : IDLE;
    cand_x = dir_x ? pos_t'({1'b0, o_ball_x}) + X_STEP : pos_t'({1'b0, o_ball_x}) - X_STEP;
    cand_y = dir_y ? pos_t'({1'b0, o_ball_y}) + Y_STEP : pos_t'({1'b0, o_ball_y}) - Y_STEP;
    hi_x = cand_x > X_MAX;
    lo_x = cand_x[10];
    hi_y = cand_y > Y_MAX;
    lo_y = cand_y[10];
    on = i_visible
      && {1'b0, i_hpos} >= {1'b0, o_ball_x} && {1'b0, i_hpos} < {1'b0, o_ball_x} + BS
      && {1'b0, i_vpos} >= {1'b0, o_ball_y} && {1'b0, i_vpos} < {1'b0, o_ball_y} + BS;
  end
  // busy also covers the cycle after STEP_Y so it falls one edge after the FSM returns to IDLE
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_bounce_x <= 1'b0;
      o_bounce_y <= 1'b0;
      o_ball_on  <= 1'b0;
      o_ball_x   <= 10'(X_INIT);
      o_ball_y   <= 10'(Y_INIT);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else begin
      state      <= state_n;
      o_busy     <= (state_n != IDLE) || (state == STEP_Y);
      o_bounce_x <= (state == STEP_X) && (hi_x || lo_x);
      o_bounce_y <= (state == STEP_Y) && (hi_y || lo_y);
      o_ball_on  <= on;
      if (state == STEP_X) begin
        o_ball_x <= hi_x ? X_MAX[9:0] : lo_x ? 10'd0 : cand_x[9:0];
        dir_x    <= hi_x ? 1'b0 : lo_x ? 1'b1 : dir_x;
      end
      if (state == STEP_Y) begin
        o_ball_y <= hi_y ? Y_MAX[9:0] : lo_y ? 10'd0 : cand_y[9:0];
        dir_y    <= hi_y ? 1'b0 : lo_y ? 1'b1 : dir_y;
      end
    end
`ifdef BALL_MOTION_BOUNCE_COUNT_EN
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, o_bounce_count} + 17'(o_bounce_x) + 17'(o_bounce_y);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_bounce_count <= 16'd0;
    else o_bounce_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
`endif
endmodule

// File: tb/tb_ball_motion_controller.sv
// tb_ball_motion_controller: scoreboard bench for ball_motion_controller with a default and a near-corner instance
module tb_ball_motion_controller;
  typedef struct {
    int x[2];
    int y[2];
    bit bx[2];
    bit by[2];
    int cnt[2];
  } frame_exp_t;
  typedef struct {
    bit on[2];
  } on_exp_t;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b1, enable = 1'b1, visible = 1'b0;
  logic [9:0] hpos = '0, vpos = '0;
  logic [9:0] bx0, by0, bx1, by1;
  logic on0, on1, busy0, busy1, bnx0, bny0, bnx1, bny1;
  logic [15:0] cnt0, cnt1;
  int n_chk = 0, n_pass = 0;
  int mx[2], my[2], mcnt[2];
  bit mdx[2], mdy[2];
  frame_exp_t sb[$];
  on_exp_t osb[$];
  always #5 clk = ~clk;
  ball_motion_controller dut0 (
    .i_clk(clk), .i_rst(rst), .i_vsync(vsync), .i_enable(enable),
    .i_hpos(hpos), .i_vpos(vpos), .i_visible(visible),
    .o_ball_x(bx0), .o_ball_y(by0), .o_ball_on(on0), .o_busy(busy0),
    .o_bounce_x(bnx0), .o_bounce_y(bny0)
`ifdef BALL_MOTION_BOUNCE_COUNT_EN
    , .o_bounce_count(cnt0)
`endif
  );
  ball_motion_controller #(.X_INIT(631), .Y_INIT(471)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_vsync(vsync), .i_enable(enable),
    .i_hpos(hpos), .i_vpos(vpos), .i_visible(visible),
    .o_ball_x(bx1), .o_ball_y(by1), .o_ball_on(on1), .o_busy(busy1),
    .o_bounce_x(bnx1), .o_bounce_y(bny1)
`ifdef BALL_MOTION_BOUNCE_COUNT_EN
    , .o_bounce_count(cnt1)
`endif
  );
`ifndef BALL_MOTION_BOUNCE_COUNT_EN
  assign cnt0 = 16'd0;
  assign cnt1 = 16'd0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic void step(input int p, input bit d, input int lim,
                               output int np, output bit nd, output bit b);
    int c;
    c = d ? p + 2 : p - 2;
    if (c > lim) begin np = lim; nd = 1'b0; b = 1'b1; end
    else if (c < 0) begin np = 0; nd = 1'b1; b = 1'b1; end
    else begin np = c; nd = d; b = 1'b0; end
  endfunction
  function automatic bit on_model(input int h, input int v, input bit vis, input int x, input int y);
    return vis && h >= x && h < x + 8 && v >= y && v < y + 8;
  endfunction
  task automatic reset_model();
    mx = '{128, 631};
    my = '{128, 471};
    mdx = '{1'b1, 1'b1};
    mdy = '{1'b1, 1'b1};
    mcnt = '{0, 0};
  endtask
  task automatic check_pos(input frame_exp_t e, input bit with_y);
    check("x0", 32'(bx0), e.x[0]);
    check("x1", 32'(bx1), e.x[1]);
    if (with_y) begin
      check("y0", 32'(by0), e.y[0]);
      check("y1", 32'(by1), e.y[1]);
    end
  endtask
  task automatic frame(input bit en);
    frame_exp_t e;
    enable = en;
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        step(mx[i], mdx[i], 632, e.x[i], mdx[i], e.bx[i]);
        step(my[i], mdy[i], 472, e.y[i], mdy[i], e.by[i]);
        mx[i] = e.x[i];
        my[i] = e.y[i];
        mcnt[i] = mcnt[i] + int'(e.bx[i]) + int'(e.by[i]);
        e.cnt[i] = mcnt[i] > 65535 ? 65535 : mcnt[i];
      end
      sb.push_back(e);
    end
    @(negedge clk);
    vsync = 1'b0;
    if (en) begin
      @(negedge clk);
      e = sb.pop_front();
      check("busy_T", 32'(busy0), 1);
      check("bx_early", 32'(bnx0), 0);
      vsync = 1'b1;
      @(negedge clk);
      check_pos(e, 1'b0);
      check("bounce_x0", 32'(bnx0), 32'(e.bx[0]));
      check("bounce_x1", 32'(bnx1), 32'(e.bx[1]));
      vsync = 1'b0;
      @(negedge clk);
      check_pos(e, 1'b1);
      check("bounce_y0", 32'(bny0), 32'(e.by[0]));
      check("bounce_y1", 32'(bny1), 32'(e.by[1]));
      check("bx_pulse_len", 32'(bnx1), 0);
      check("busy_T2", 32'(busy1), 1);
      @(negedge clk);
      check("busy_T3", 32'(busy0 | busy1), 0);
      check("by_pulse_len", 32'(bny1), 0);
`ifdef BALL_MOTION_BOUNCE_COUNT_EN
      check("count0", 32'(cnt0), e.cnt[0]);
      check("count1", 32'(cnt1), e.cnt[1]);
`endif
      vsync = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("busy_disabled", 32'(busy0 | busy1), 0);
      end
      vsync = 1'b1;
      e.x = mx;
      e.y = my;
      check_pos(e, 1'b1);
    end
    @(negedge clk);
  endtask
  initial begin
    int tbl[15][3];
    on_exp_t oe;
    frame_exp_t e;
    tbl = '{'{127,130,1}, '{128,130,1}, '{129,130,1}, '{131,130,1}, '{135,130,1},
            '{136,130,1}, '{130,127,1}, '{130,128,1}, '{130,135,1}, '{130,136,1},
            '{130,130,0}, '{630,475,1}, '{631,471,1}, '{638,478,1}, '{639,475,1}};
    reset_model();
    repeat (3) @(negedge clk);
    check("rst_x0", 32'(bx0), 128);
    check("rst_y0", 32'(by0), 128);
    check("rst_x1", 32'(bx1), 631);
    check("rst_busy", 32'(busy0), 0);
    check("rst_bounce", 32'({bnx0, bny0}), 0);
    check("rst_on", 32'(on0), 0);
    check("rst_count", 32'(cnt0), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      hpos = 10'(tbl[i][0]);
      vpos = 10'(tbl[i][1]);
      visible = tbl[i][2][0];
      for (int d = 0; d < 2; d++) oe.on[d] = on_model(tbl[i][0], tbl[i][1], tbl[i][2][0], mx[d], my[d]);
      osb.push_back(oe);
      @(negedge clk);
      oe = osb.pop_front();
      check($sformatf("on0_h%0d_v%0d", tbl[i][0], tbl[i][1]), 32'(on0), 32'(oe.on[0]));
      check($sformatf("on1_h%0d_v%0d", tbl[i][0], tbl[i][1]), 32'(on1), 32'(oe.on[1]));
    end
    visible = 1'b0;
    frame(1'b1);
    repeat (3) frame(1'b0);
    repeat (600) frame(1'b1);
    enable = 1'b1;
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_x0", 32'(bx0), 128);
    check("midrst_y0", 32'(by0), 128);
    check("midrst_x1", 32'(bx1), 631);
    check("midrst_y1", 32'(by1), 471);
    check("midrst_busy", 32'(busy0 | busy1), 0);
    check("midrst_bounce", 32'({bnx1, bny1}), 0);
    check("midrst_count", 32'(cnt1), 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    frame(1'b1);
    e.x = mx;
    e.y = my;
    check_pos(e, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
